fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the control unit.
- Maintains the PC and issues single-outstanding requests to instruction memory, which may take a variable number of cycles to answer.
- Registers each fetched word with its PC+4 and drives opCode (instr[31:26]) straight into the control unit.
- Supports a decode stall from the hazard logic and a redirect (flush) on a taken branch or jump.

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
//
// Holds the PC and issues one request at a time to an instruction memory
// with variable latency. Each returned word is registered together with its
// PC+4, and opCode is taken straight from the registered word for the
// control unit. A decode stall parks a returning word in a one-entry skid
// buffer. A taken branch or a jump redirects the PC and flushes IF/ID.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   imem_req, imem_addr            request to instruction memory (held to imem_valid)
//   imem_rdata, imem_valid         returned word and one-cycle completion strobe
//   stall                          hold IF/ID, accept no new instruction
//   jump, jump_target              redirect (wins over branch)
//   branch_taken, branch_target    redirect
//   id_instr, id_pc_plus4, id_valid  IF/ID register contents
//   opCode                         id_instr[31:26]
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request; next cycle start fetching at pc
// REQ   | request at req_addr outstanding
// HOLD  | word returned during stall, parked in skid buffer; no request
// DRAIN | redirected while a request was in flight; wait for and drop it
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_valid,
    input  logic                  stall,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [31:0]           id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4,
    output logic                  id_valid,
    output logic [5:0]            opCode
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           buf_instr;
    logic [ADDR_WIDTH-1:0] buf_pc_plus4;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] raw_target;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] req_next;

    assign redirect   = jump | branch_taken;
    assign raw_target = jump ? jump_target : branch_target;
    // Targets are forced word aligned.
    assign target     = raw_target & ~ADDR_WIDTH'(3);
    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign req_next   = req_addr + ADDR_WIDTH'(4);

    assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
    assign imem_addr = req_addr;
    assign opCode    = id_instr[31:26];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            id_instr     <= '0;
            id_pc_plus4  <= '0;
            id_valid     <= 1'b0;
            buf_instr    <= '0;
            buf_pc_plus4 <= '0;
        end else begin
            // A redirect flushes IF/ID from any state and overrides stall.
            if (redirect) begin
                pc       <= target;
                id_valid <= 1'b0;
                id_instr <= '0;
            end

            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    req_addr <= redirect ? target : pc;
                end

                S_REQ: begin
                    if (imem_valid) begin
                        if (redirect) begin
                            // Returned word is on the wrong path: drop it.
                            req_addr <= target;
                        end else if (stall) begin
                            buf_instr    <= imem_rdata;
                            buf_pc_plus4 <= req_next;
                            pc           <= req_next;
                            state        <= S_HOLD;
                        end else begin
                            id_instr    <= imem_rdata;
                            id_pc_plus4 <= req_next;
                            id_valid    <= 1'b1;
                            pc          <= req_next;
                            req_addr    <= req_next;
                        end
                    end else if (redirect) begin
                        // Memory still owes us a word for req_addr; keep the
                        // request asserted and unchanged until it arrives.
                        state <= S_DRAIN;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        req_addr <= target;
                        state    <= S_REQ;
                    end else if (!stall) begin
                        id_instr    <= buf_instr;
                        id_pc_plus4 <= buf_pc_plus4;
                        id_valid    <= 1'b1;
                        req_addr    <= pc;
                        state       <= S_REQ;
                    end
                end

                S_DRAIN: begin
                    // A redirect arriving together with the stale word must
                    // still end the drain, otherwise nothing would complete it.
                    if (imem_valid) begin
                        req_addr <= redirect ? target : pc;
                        state    <= S_REQ;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
